// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU control decode and load-use detection.
// Latency: one edge from decode inputs to a/b/controle; stall holds, flush or load_use inserts a bubble.
module id_ex_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] in_rs_data,
  input  logic [31:0] in_rt_data,
  input  logic [31:0] in_imm,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [5:0]  in_funct,
  input  logic [7:0]  in_ctrl,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [3:0]  controle,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_wr_reg,
  output logic [3:0]  out_ctrl,
  output logic        out_valid,
  output logic        load_use
);

  logic [31:0] rs_data_q, rt_data_q, imm_q;
  logic [4:0]  rs_q, rt_q, wr_reg_q;
  logic [5:0]  funct_q;
  logic [1:0]  alu_op_q;
  logic        alu_src_q;
  logic [3:0]  ctrl_q;
  logic        valid_q;
  logic        bubble;
  logic [31:0] fa, fb;

  // A load in EX whose destination feeds the instruction now in decode.
  assign load_use = valid_q & ctrl_q[2] & (wr_reg_q != 5'd0) & in_valid &
                    ((wr_reg_q == in_rs) | (wr_reg_q == in_rt));

  assign bubble = flush | (~stall & load_use);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      wr_reg_q  <= '0;
      funct_q   <= '0;
      alu_op_q  <= '0;
      alu_src_q <= 1'b0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
    end else if (bubble) begin
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      wr_reg_q  <= '0;
      funct_q   <= '0;
      alu_op_q  <= '0;
      alu_src_q <= 1'b0;
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
    end else if (!stall) begin
      rs_data_q <= in_rs_data;
      rt_data_q <= in_rt_data;
      imm_q     <= in_imm;
      rs_q      <= in_rs;
      rt_q      <= in_rt;
      wr_reg_q  <= in_ctrl[4] ? in_rd : in_rt;
      funct_q   <= in_funct;
      alu_op_q  <= in_ctrl[7:6];
      alu_src_q <= in_ctrl[5];
      ctrl_q    <= in_valid ? in_ctrl[3:0] : 4'd0;
      valid_q   <= in_valid;
    end
  end

  // EX/MEM is the younger result, so it wins over MEM/WB.
  always_comb begin
    fa = rs_data_q;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rs_q)
      fa = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs_q)
      fa = memwb_result;
  end

  always_comb begin
    fb = rt_data_q;
    if (exmem_reg_write && exmem_rd != 5'd0 && exmem_rd == rt_q)
      fb = exmem_result;
    else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rt_q)
      fb = memwb_result;
  end

  assign a              = fa;
  assign b              = alu_src_q ? imm_q : fb;
  assign out_store_data = fb;
  assign out_wr_reg     = wr_reg_q;
  assign out_ctrl       = ctrl_q;
  assign out_valid      = valid_q;

  always_comb begin
    controle = 4'b0000;
    if (valid_q) begin
      case (alu_op_q)
        2'b00: controle = 4'b0000;
        2'b01: controle = 4'b0010;
        2'b11: controle = 4'b0101;
        default: begin
          case (funct_q)
            6'b100000, 6'b100001: controle = 4'b0000;
            6'b100010, 6'b100011: controle = 4'b0010;
            6'b100100:            controle = 4'b0100;
            6'b100101:            controle = 4'b0101;
            6'b100110:            controle = 4'b0111;
            6'b100111:            controle = 4'b0110;
            6'b101010:            controle = 4'b1000;
            default:              controle = 4'b1111;
          endcase
        end
      endcase
    end
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clock  in  1  pipeline clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; low clears all state immediately, independent of clock.
REQ-003 stall  in  1  pipeline hold; 1 = keep current contents.
REQ-004 flush  in  1  1 = load bubble on next edge (branch/jump squash).
REQ-005 in_valid  in  1  decode stage holds a real instruction.
REQ-006 in_rs_data, in_rt_data, in_imm  in  32 each  register file reads; in_imm already sign-extended.
REQ-007 in_rs, in_rt, in_rd  in  5 each  register indices.
REQ-008 in_funct  in  6  R-type funct field.
REQ-009 in_ctrl  in  8  [7:6] alu_op, [5] alu_src, [4] reg_dst, [3] reg_write, [2] mem_read, [1] mem_write, [0] mem_to_reg.
REQ-010 exmem_reg_write, memwb_reg_write  in  1 each; exmem_rd, memwb_rd  in  5 each; exmem_result, memwb_result  in  32 each  forwarding sources.
REQ-011 controle  out  4  ALU operation code; a, b  out  32 each  ALU operands.
REQ-012 out_store_data  out  32  forwarded rt value for stores.
REQ-013 out_wr_reg  out  5; out_ctrl  out  4  {reg_write, mem_read, mem_write, mem_to_reg}; out_valid  out  1.
REQ-014 load_use  out  1  load-use hazard flag to fetch/decode stages (they must hold when 1).

Function
REQ-015 The stage SHALL register rs_data, rt_data, imm, rs, rt, funct, alu_op, alu_src, wr_reg, out_ctrl and out_valid on each rising edge per REQ-016..019.
REQ-016 Priority SHALL be flush > stall > load_use > capture.
REQ-017 flush=1: out_valid<=0, out_ctrl<=0, alu_op<=00, alu_src<=0, rs<=0, rt<=0; data fields don't-care.
REQ-018 stall=1 (no flush): all registers SHALL hold.
REQ-019 load_use=1 (no flush, no stall): bubble loaded as in REQ-017; otherwise capture inputs, out_valid<=in_valid, out_ctrl<=in_valid ? in_ctrl[3:0] : 0, wr_reg<=in_ctrl[4] ? in_rd : in_rt.
REQ-020 load_use SHALL be combinational: out_valid & out_ctrl[2] & (out_wr_reg!=0) & in_valid & (out_wr_reg==in_rs | out_wr_reg==in_rt).
REQ-021 Forwarded rs (fa): exmem_result if exmem_reg_write & exmem_rd!=0 & exmem_rd==rs; else memwb_result if memwb_reg_write & memwb_rd!=0 & memwb_rd==rs; else registered rs_data. Forwarded rt (fb) identically on rt.
REQ-022 a SHALL equal fa; b SHALL equal alu_src ? imm : fb; out_store_data SHALL equal fb; all combinational, zero added latency after register.
REQ-023 controle: alu_op 00 -> 0000 (ADD); 01 -> 0010 (SUB); 11 -> 0101 (OR); 10 -> funct decode.
REQ-024 funct decode: 100000/100001 -> 0000; 100010/100011 -> 0010; 100100 -> 0100; 100101 -> 0101; 100110 -> 0111; 100111 -> 0110; 101010 -> 1000; any other -> 1111 (ALU outputs 0).
REQ-025 out_valid=0 SHALL force controle=0000 regardless of registered alu_op.
REQ-026 Register 0 SHALL never be forwarded and never raise load_use.
REQ-027 Latency: decode inputs appear on a/b/controle one edge after capture; a stalled stage presents unchanged outputs except where forwarding sources change.

Reset
REQ-028 reset low SHALL clear every register to 0: out_valid=0, out_ctrl=0000, out_wr_reg=0, controle=0000, a=0, b=0, out_store_data=0, load_use=0.
REQ-029 Reset release SHALL take effect on the first rising edge after reset goes high; reset mid-stall or mid-flush discards held contents.

Verification
REQ-030 Capture: in_valid=1, in_ctrl=8'b10011000, in_funct=100010, in_rs_data=9, in_rt_data=4, one edge -> controle=0010, a=9, b=4, out_ctrl=1000, out_valid=1.
REQ-031 Forward priority: registered rs=5; exmem_rd=5 result=0x11, memwb_rd=5 result=0x22, both reg_write=1 -> a=0x11; drop exmem_reg_write -> a=0x22; rs=0 -> a=rs_data.
REQ-032 Load-use: registered lw (mem_read=1, wr_reg=8), in_rs=8, in_valid=1 -> load_use=1; next edge out_valid=0, out_ctrl=0; same with wr_reg=0 -> load_use=0.
REQ-033 Flush vs stall: flush=1 and stall=1 on same edge -> out_valid=0; stall alone for 3 edges -> outputs unchanged.
REQ-034 Async reset: assert reset low between edges with out_valid=1 -> out_valid, a, b, controle all 0 before next edge; unknown funct 111111 with alu_op=10 after reset -> controle=1111.
